// File: rtl/br_pkg.sv
// rtl/br_pkg.sv - shared encodings and defaults for the branch resolution stage
package br_pkg;

    // Branch condition encodings carried on br_op
    localparam logic [1:0] BR_BEQ = 2'd0;
    localparam logic [1:0] BR_BNE = 2'd1;
    localparam logic [1:0] BR_BGT = 2'd2;
    localparam logic [1:0] BR_BLT = 2'd3;

    // Resolution FSM states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RESOLVE = 2'd1,
        ST_FLUSH   = 2'd2
    } br_state_t;

    // Default flush length after a taken redirect (legal 1..7)
    localparam int FLUSH_CYC_DEFAULT = 2;

    // Flush counter width, wide enough for FLUSH_CYC-1 up to 6
    localparam int CNT_W = 3;

endpackage

// File: rtl/br_cond_eval.sv
// rtl/br_cond_eval.sv - combinational branch condition evaluation from comparator flags
//
// Ports:
//   op     in  2 : branch condition (BR_BEQ/BR_BNE/BR_BGT/BR_BLT)
//   gtr    in  1 : comparator in1 > in2
//   lte    in  1 : comparator in1 < in2 (strict)
//   eq     in  1 : comparator in1 == in2
//   taken  out 1 : branch condition holds
module br_cond_eval
    import br_pkg::*;
(
    input  logic [1:0] op,
    input  logic       gtr,
    input  logic       lte,
    input  logic       eq,
    output logic       taken
);

    // Each op looks only at its own flag; illegal multi-flag inputs are not screened.
    always_comb begin
        taken = 1'b0;
        case (op)
            BR_BEQ:  taken = eq;
            BR_BNE:  taken = !eq;
            BR_BGT:  taken = gtr;
            BR_BLT:  taken = lte;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve.sv
// rtl/branch_resolve.sv - conditional branch resolution, PC redirect and flush sequencing
//
// Optional build macro: BR_STATS_EN adds saturating taken/not-taken counters.
//
// Parameters:
//   FLUSH_CYC : cycles flush stays high after a taken redirect (1..7)
//   AW        : PC/target width
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   br_valid / br_ready   : branch request handshake (ready == FSM idle)
//   br_op, br_target      : branch condition and taken target
//   brGtr, brLte, brEq    : comparator flags, valid the cycle after acceptance
//   stall                 : holds resolution, flags not sampled while high
//   pc_sel, pc_next       : one-cycle redirect pulse and registered target
//   flush                 : squash younger instructions
//   br_done               : one-cycle retire pulse
//   br_taken              : outcome of last resolved branch
//   stat_taken, stat_ntaken, stat_clr : outcome counters and clear (BR_STATS_EN only)
module branch_resolve
    import br_pkg::*;
#(
    parameter int FLUSH_CYC = FLUSH_CYC_DEFAULT,
    parameter int AW        = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          br_valid,
    output logic          br_ready,
    input  logic [1:0]    br_op,
    input  logic [AW-1:0] br_target,
    input  logic          brGtr,
    input  logic          brLte,
    input  logic          brEq,
    input  logic          stall,
`ifdef BR_STATS_EN
    input  logic          stat_clr,
    output logic [15:0]   stat_taken,
    output logic [15:0]   stat_ntaken,
`endif
    output logic          pc_sel,
    output logic [AW-1:0] pc_next,
    output logic          flush,
    output logic          br_done,
    output logic          br_taken
);

    br_state_t      state;
    logic [1:0]     op_q;
    logic [AW-1:0]  target_q;
    logic [CNT_W-1:0] cnt;
    logic           cond_taken;
    logic           resolve_fire;

    br_cond_eval u_cond (
        .op    (op_q),
        .gtr   (brGtr),
        .lte   (brLte),
        .eq    (brEq),
        .taken (cond_taken)
    );

    assign br_ready     = (state == ST_IDLE);
    assign resolve_fire = (state == ST_RESOLVE) && !stall;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            op_q     <= 2'd0;
            target_q <= '0;
            cnt      <= '0;
            pc_sel   <= 1'b0;
            pc_next  <= '0;
            flush    <= 1'b0;
            br_done  <= 1'b0;
            br_taken <= 1'b0;
        end else begin
            pc_sel  <= 1'b0;
            br_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (br_valid) begin
                        op_q     <= br_op;
                        target_q <= br_target;
                        state    <= ST_RESOLVE;
                    end
                end
                ST_RESOLVE: begin
                    if (!stall) begin
                        br_taken <= cond_taken;
                        if (cond_taken) begin
                            pc_sel  <= 1'b1;
                            pc_next <= target_q;
                            flush   <= 1'b1;
                            cnt     <= CNT_W'(FLUSH_CYC - 1);
                            // With a one-cycle flush the first flush cycle is also the last.
                            br_done <= (FLUSH_CYC == 1);
                            state   <= ST_FLUSH;
                        end else begin
                            br_done <= 1'b1;
                            state   <= ST_IDLE;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (cnt == '0) begin
                        flush <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                        // br_done lands in the cycle where the counter reads 0.
                        br_done <= (cnt == CNT_W'(1));
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef BR_STATS_EN
    // Clear beats a coincident increment; both counters stick at all-ones.
    always_ff @(posedge clk) begin
        if (!rst_n || stat_clr) begin
            stat_taken  <= 16'h0000;
            stat_ntaken <= 16'h0000;
        end else if (resolve_fire) begin
            if (cond_taken) begin
                if (stat_taken != 16'hFFFF) stat_taken <= stat_taken + 16'h0001;
            end else begin
                if (stat_ntaken != 16'hFFFF) stat_ntaken <= stat_ntaken + 16'h0001;
            end
        end
    end
`endif

endmodule
